// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Checks a divided clock against the fast clock it was derived from.
// i_div_clk is synchronised into the i_clk domain, and its period and high
// time are measured in i_clk cycles. Both are compared with RATIO and
// RATIO/2, within TOL. The block reports lock after LOCK_CNT consecutive
// good periods, and pulses an error on a bad period, a bad duty cycle, or a
// missing edge (timeout).
//
// Ports
//   i_clk      fast reference clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_en       monitor enable; low returns to IDLE and clears lock
//   i_div_clk  divided clock under test (asynchronous)
//   o_period   last measured period in i_clk cycles
//   o_high     last measured high time in i_clk cycles
//   o_valid    one-cycle pulse when o_period/o_high update
//   o_locked   LOCK_CNT consecutive good periods seen
//   o_err      one-cycle pulse on bad period, bad duty or timeout
module clk_div_monitor #(
  parameter int unsigned RATIO        = 8,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned TIMEOUT_MULT = 4,
  parameter int unsigned TOL          = 0,
  localparam int unsigned W = $clog2(RATIO * TIMEOUT_MULT) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_div_clk,
  output logic [W-1:0] o_period,
  output logic [W-1:0] o_high,
  output logic         o_valid,
  output logic         o_locked,
  output logic         o_err
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  TIMEOUT = W'(RATIO * TIMEOUT_MULT);
  localparam logic [W:0]    EXP_P   = (W+1)'(RATIO);
  localparam logic [W:0]    EXP_H   = (W+1)'(RATIO / 2);
  localparam logic [W:0]    TOL_W   = (W+1)'(TOL);
  localparam logic [MW-1:0] MC_MAX  = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} state_t;

  state_t        state, state_nxt;
  logic          s1, s, s_d;
  logic          rise, fall, active, good;
  logic [W-1:0]  cnt, hcnt, high_lat;
  logic [MW-1:0] mc, mc_nxt;
  logic          valid_nxt, err_nxt, locked_nxt;

  // Unsigned |a-b|. The operands are widened by one bit so the subtraction
  // cannot wrap.
  function automatic logic [W:0] absdiff(input logic [W:0] a, input logic [W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign active = i_en && (state != IDLE);
  assign good   = (absdiff({1'b0, cnt}, EXP_P) <= TOL_W) &&
                  (absdiff({1'b0, high_lat}, EXP_H) <= TOL_W);

  // Two synchroniser flops, then one delay flop for edge detection. The
  // latency is constant, so rise-to-rise distances are exact.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= i_div_clk;
      s   <= s1;
      s_d <= s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= '0;
      hcnt     <= '0;
      high_lat <= '0;
    end else if (!active) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise)            cnt <= W'(1);
      else if (cnt != '1)  cnt <= cnt + W'(1);
      if (rise)                   hcnt <= W'(1);
      else if (s && hcnt != '1)   hcnt <= hcnt + W'(1);
      // If there is no fall in a period, the old high time stays here.
      // The period check then catches the stuck input.
      if (fall) high_lat <= hcnt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mc_nxt     = mc;
    locked_nxt = o_locked;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    if (!i_en) begin
      state_nxt  = IDLE;
      mc_nxt     = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE:  state_nxt = ALIGN;
        ALIGN: if (rise) state_nxt = MEASURE;
        MEASURE: begin
          // A rise takes priority over reaching the timeout threshold.
          if (rise) begin
            valid_nxt = 1'b1;
            if (good) begin
              mc_nxt     = (mc == MC_MAX) ? mc : mc + MW'(1);
              locked_nxt = (mc_nxt == MC_MAX);
            end else begin
              err_nxt    = 1'b1;
              mc_nxt     = '0;
              locked_nxt = 1'b0;
            end
          end else if (cnt == TIMEOUT) begin
            err_nxt    = 1'b1;
            mc_nxt     = '0;
            locked_nxt = 1'b0;
            state_nxt  = ALIGN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      mc       <= '0;
      o_period <= '0;
      o_high   <= '0;
      o_valid  <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      mc       <= mc_nxt;
      o_valid  <= valid_nxt;
      o_err    <= err_nxt;
      o_locked <= locked_nxt;
      if (valid_nxt) begin
        o_period <= cnt;
        o_high   <= high_lat;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor. The model works on event timestamps:
// period = distance between detected rises, high = fall minus rise. The
// output of every cycle is compared with this model, and literal checks at
// the end of each phase pin the model.
module tb_clk_div_monitor;

  localparam int W = 6;
  localparam int RATIO = 8;
  localparam int LOCK = 4;
  localparam int TMO = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         div = 1'b0;
  logic [W-1:0] o_period, o_high;
  logic         o_valid, o_locked, o_err;

  int checks = 0;
  int errors = 0;

  clk_div_monitor #(.RATIO(8), .LOCK_CNT(4), .TIMEOUT_MULT(4), .TOL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_div_clk(div),
    .o_period(o_period), .o_high(o_high), .o_valid(o_valid),
    .o_locked(o_locked), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 disabled/idle, 1 waiting for a first edge, 2 measuring
  int   mode = 0, cyc = 0, last_rise = 0, hi = 0, good_run = 0;
  bit   have_rise = 0;
  bit   hist [3] = '{0, 0, 0};  // input samples 1, 2 and 3 cycles ago
  int   e_period = 0, e_high = 0;
  bit   e_valid = 0, e_err = 0, e_locked = 0;

  always @(posedge clk or posedge rst) begin
    bit r, f;
    int per;
    if (rst) begin
      mode = 0; good_run = 0; have_rise = 0; hi = 0;
      hist = '{0, 0, 0};
      e_period = 0; e_high = 0; e_valid = 0; e_err = 0; e_locked = 0;
    end else begin
      cyc++;
      r = hist[1] && !hist[2];
      f = !hist[1] && hist[2];
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = div;
      e_valid = 0; e_err = 0;
      if (!en) begin
        mode = 0; good_run = 0; e_locked = 0; have_rise = 0;
      end else begin
        if (mode != 0 && f && have_rise) hi = cyc - last_rise;
        case (mode)
          0: mode = 1;
          1: if (r) begin mode = 2; last_rise = cyc; have_rise = 1; end
          default: begin
            if (r) begin
              per = cyc - last_rise;
              e_valid = 1; e_period = per; e_high = hi;
              if (per == RATIO && hi == RATIO / 2) begin
                if (good_run < LOCK) good_run++;
                e_locked = (good_run == LOCK);
              end else begin
                e_err = 1; good_run = 0; e_locked = 0;
              end
              last_rise = cyc;
            end else if (cyc - last_rise == TMO) begin
              e_err = 1; good_run = 0; e_locked = 0; mode = 1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (o_period !== W'(e_period) || o_high !== W'(e_high) ||
          o_valid !== e_valid || o_err !== e_err || o_locked !== e_locked) begin
        errors++;
        $display("FAIL cycle_model t=%0t: got per=%0d hi=%0d v=%0b e=%0b l=%0b, expected per=%0d hi=%0d v=%0b e=%0b l=%0b",
                 $time, o_period, o_high, o_valid, o_err, o_locked,
                 e_period, e_high, e_valid, e_err, e_locked);
      end
    end
  end

  // running totals of DUT pulses, for the phase-level literal checks
  int  vtot = 0, etot = 0, lock_at = -1;
  logic prev_locked = 1'b0;
  always @(negedge clk) begin
    if (o_valid === 1'b1) vtot++;
    if (o_err === 1'b1) etot++;
    if (o_locked === 1'b1 && prev_locked !== 1'b1) lock_at = vtot;
    prev_locked = o_locked;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) begin @(negedge clk); div = 1'b1; end
      for (int i = 0; i < l; i++) begin @(negedge clk); div = 1'b0; end
    end
    #1;
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); div = 1'b0; end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, int'(o_period), 0);
    chk({tag, "_high"},   int'(o_high), 0);
    chk({tag, "_valid"},  int'(o_valid), 0);
    chk({tag, "_locked"}, int'(o_locked), 0);
    chk({tag, "_err"},    int'(o_err), 0);
  endtask

  int v0, e0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); rst = 1'b0; en = 1'b1; #1;

    // lock on a nominal clock
    v0 = vtot; e0 = etot;
    run(4, 4, 7);
    chk("nom_lock_valids", lock_at - v0, 4);
    chk("nom_locked", int'(o_locked), 1);
    chk("nom_period", int'(o_period), 8);
    chk("nom_high", int'(o_high), 4);
    chk("nom_errs", etot - e0, 0);

    // wrong period, 5 high / 4 low
    e0 = etot;
    run(5, 4, 3);
    chk("wp_errs", etot - e0, 2);
    chk("wp_locked", int'(o_locked), 0);
    chk("wp_period", int'(o_period), 9);
    chk("wp_high", int'(o_high), 5);

    // relock, then one 3/5 period
    run(4, 4, 6);
    chk("relock_locked", int'(o_locked), 1);
    e0 = etot;
    run(3, 5, 1);
    run(4, 4, 1);
    chk("duty_period", int'(o_period), 8);
    chk("duty_high", int'(o_high), 3);
    chk("duty_locked", int'(o_locked), 0);
    chk("duty_errs", etot - e0, 1);
    v0 = vtot;
    run(4, 4, 6);
    chk("duty_relock_valids", lock_at - v0, 4);

    // timeout: hold low
    v0 = vtot; e0 = etot;
    hold_low(40);
    chk("tmo_errs", etot - e0, 1);
    chk("tmo_valids", vtot - v0, 0);
    chk("tmo_locked", int'(o_locked), 0);
    v0 = vtot; e0 = etot;
    run(4, 4, 3);
    chk("tmo_resume_valids", vtot - v0, 2);
    chk("tmo_resume_errs", etot - e0, 0);

    // asynchronous reset mid-period while locked
    run(4, 4, 6);
    chk("pre_rst_locked", int'(o_locked), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    v0 = vtot;
    run(4, 4, 7);
    chk("rst_relock_valids", lock_at - v0, 4);
    chk("rst_relock_locked", int'(o_locked), 1);

    // enable drop while locked
    v0 = vtot; e0 = etot;
    @(negedge clk); en = 1'b0;
    @(negedge clk); #1;
    chk("en_drop_locked", int'(o_locked), 0);
    run(4, 4, 3);
    chk("en_off_valids", vtot - v0, 0);
    chk("en_off_errs", etot - e0, 0);
    chk("en_off_period", int'(o_period), 8);
    chk("en_off_high", int'(o_high), 4);
    en = 1'b1;
    v0 = vtot;
    run(4, 4, 7);
    chk("en_relock_valids", lock_at - v0, 4);
    chk("en_relock_locked", int'(o_locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Measures a divided clock against the fast clock it was derived from.
- Samples i_div_clk in the i_clk domain and measures its period and high time in i_clk cycles.
- Compares both against the configured RATIO and reports lock or error.
- Sits beside the integer clock dividers as their checker, for bring-up and in-system health monitoring.

Parameters:
RATIO, 8, expected division ratio; power of two, >= 2
LOCK_CNT, 4, consecutive good periods required to assert o_locked; >= 1
TIMEOUT_MULT, 4, no-edge timeout = RATIO*TIMEOUT_MULT i_clk cycles
TOL, 0, allowed |measured - expected| in cycles, for both period and high time
W, $clog2(RATIO*TIMEOUT_MULT)+1, measurement width (derived localparam, not overridable)

Ports:
i_clk  input  1  fast reference clock; all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_en  input  1  monitor enable; low forces IDLE
i_div_clk  input  1  divided clock under test, treated as asynchronous data
o_period  output  W  last measured period (i_clk cycles)
o_high  output  W  last measured high time (i_clk cycles)
o_valid  output  1  one-cycle pulse when o_period/o_high update
o_locked  output  1  LOCK_CNT consecutive good periods seen
o_err  output  1  one-cycle pulse on bad period, bad duty, or timeout

Behaviour:
- Reset (async, immediate) clears:
  - synchronizer, FSM (to IDLE), counters, match count, latched high time
  - all outputs to 0
- Input path:
  - 2-flop synchronizer on i_div_clk, then one delay flop for edge detect.
  - rise = s & ~s_d; fall = ~s & s_d. Detection latency 3 i_clk cycles, constant, so periods are exact.
- cnt (W bits), period measurement:
  - On a rise cycle, cnt <= 1; otherwise cnt++ (saturates at all-ones).
  - Period captured at a rise = current cnt value, so edges R cycles apart give R.
- hcnt (W bits), high-time measurement:
  - On rise, hcnt <= 1; on cycles with s=1 and no rise, hcnt++.
  - On fall, high_lat <= hcnt.
- FSM:
  - IDLE: wait for i_en=1 -> ALIGN.
  - ALIGN: wait first rise; start cnt/hcnt, no measurement -> MEASURE.
  - MEASURE, on each rise:
    - o_period <= cnt; o_high <= high_lat; o_valid=1 for one cycle.
    - good = |cnt-RATIO| <= TOL AND |high_lat-RATIO/2| <= TOL.
    - good: match count++ (saturates at LOCK_CNT); o_locked=1 once match count reaches LOCK_CNT, registered same cycle as the valid pulse.
    - bad: o_err pulse; match count <= 0; o_locked <= 0; stay in MEASURE.
  - MEASURE timeout: cnt == RATIO*TIMEOUT_MULT with no rise this cycle:
    - o_err pulse, o_locked <= 0, match count <= 0, no o_valid
    - -> ALIGN
  - Rise and timeout threshold in the same cycle: rise wins (normal measurement, no timeout).
- i_en low in any state:
  - Next cycle FSM = IDLE; o_locked, match count, counters cleared.
  - o_period/o_high hold last values; no o_valid/o_err while disabled.
- Re-enable restarts from ALIGN: first o_valid at the second rise after enable.
- No fall seen within a period (stuck-high input): high_lat keeps its stale value; the period check catches the fault.
- All arithmetic unsigned, W bits; comparisons done at W+1 bits to avoid wrap.

Test Plan:
- Lock on nominal clock:
  - Stimulus: RATIO=8; i_div_clk = i_clk/8, 4 high / 4 low; i_en=1.
  - Response: o_valid every 8 cycles with o_period=8, o_high=4; o_locked rises with the 4th o_valid; o_err never pulses.
- Wrong period:
  - Stimulus: period 9 (5 high / 4 low).
  - Response: each o_valid shows o_period=9, o_high=5 with a coincident o_err pulse; o_locked stays 0.
- Duty error:
  - Stimulus: period 8, 3 high / 5 low, after lock.
  - Response: o_period=8, o_high=3; o_err pulses; o_locked drops the same cycle.
  - Then restore 4/4: o_locked returns after 4 more good o_valid pulses.
- Timeout:
  - Stimulus: lock, then hold i_div_clk low.
  - Response: 32 cycles after the last rise detect, o_err pulses and o_locked=0; no o_valid.
  - Edges resume: first o_valid at the second new rise.
- Async reset:
  - Stimulus: assert i_rst mid-period between i_clk edges while locked.
  - Response: all outputs 0 immediately; after release, relock needs 5 rises (1 align + 4 good).
- Enable drop:
  - Stimulus: deassert i_en while locked.
  - Response: o_locked=0 next cycle; o_period/o_high hold 8/4; no pulses until re-enabled.
